// File: rtl/bus_mux_pkg.sv
// Shared types and width helpers for the round-robin bus arbiter/multiplexer.
// Pure declarations: no latency, no flow control.
package bus_mux_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_NUM_SRC = 24;

    // One code beyond the last source index, so the override never aliases a real source.
    localparam int DEF_OVR_CODE = DEF_NUM_SRC;

    function automatic int sel_width(input int num_src);
        return $clog2(num_src + 1);
    endfunction

    function automatic int ovr_code(input int num_src);
        return num_src;
    endfunction

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// Request and bus signals of bus_arbiter_mux; the ovr_* pair exists only with BUS_MUX_OVERRIDE_EN.
// No latency or backpressure of its own: requests are level-sensitive, the bus is push-only.
interface bus_arbiter_mux_if
    import bus_mux_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = DEF_NUM_SRC
);
    localparam int SEL_W = sel_width(NUM_SRC);

    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_req;
    logic [DATA_W-1:0]         bus_out;
    logic                      bus_valid;
    logic [NUM_SRC-1:0]        grant;
    logic [SEL_W-1:0]          grant_code;
`ifdef BUS_MUX_OVERRIDE_EN
    logic                      ovr_req;
    logic [DATA_W-1:0]         ovr_data;
`endif

`ifdef BUS_MUX_OVERRIDE_EN
    modport master (
        output src_data, src_req, ovr_req, ovr_data,
        input  bus_out, bus_valid, grant, grant_code
    );
    modport slave (
        input  src_data, src_req, ovr_req, ovr_data,
        output bus_out, bus_valid, grant, grant_code
    );
`else
    modport master (
        output src_data, src_req,
        input  bus_out, bus_valid, grant, grant_code
    );
    modport slave (
        input  src_data, src_req,
        output bus_out, bus_valid, grant, grant_code
    );
`endif

endinterface

// File: rtl/bus_arbiter_mux_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping; zero latency.
// No backpressure; winner_o is meaningful only while any_req_o is high.
module rr_arbiter
    import bus_mux_pkg::*;
#(
    parameter int NUM_SRC = DEF_NUM_SRC,
    localparam int SEL_W  = sel_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic [SEL_W-1:0]   winner_o,
    output logic               any_req_o
);

    logic [2*NUM_SRC-1:0] dbl;
    logic [NUM_SRC-1:0]   rot;
    int                   idx;

    always_comb begin
        dbl      = {req_i, req_i} >> ptr_i;
        rot      = dbl[NUM_SRC-1:0];
        winner_o = '0;
        idx      = 0;
        // rot[k] is source (ptr+k) mod NUM_SRC; scanning down leaves the nearest one.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = int'(ptr_i) + k;
                if (idx >= NUM_SRC) idx = idx - NUM_SRC;
                winner_o = SEL_W'(idx);
            end
        end
    end

    assign any_req_o = |req_i;

endmodule

// File: rtl/bus_arbiter_mux.sv
// Round-robin bus arbiter with bounded hold and registered bus mux; request to bus is 1 cycle.
// No backpressure; optional override input via BUS_MUX_OVERRIDE_EN.
module bus_arbiter_mux
    import bus_mux_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int MAX_HOLD = 4,
    localparam int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic              clock,
    input  logic              clear,
    bus_arbiter_mux_if.slave  bus
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    cur_q, cur_d;
    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [DATA_W-1:0]   bus_q, bus_d;
    logic                valid_q, valid_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [SEL_W-1:0]    code_q, code_d;
`ifdef BUS_MUX_OVERRIDE_EN
    localparam logic [SEL_W-1:0] OVR_CODE = SEL_W'(ovr_code(NUM_SRC));
    logic                ovr_q, ovr_d;
`endif

    logic [SEL_W-1:0]    win;
    logic                any_req;
    logic [DATA_W-1:0]   cur_dat, win_dat;
    logic [NUM_SRC-1:0]  cur_oh, win_oh;
    logic                cur_req;
    logic                keep;

    rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
        .req_i     (bus.src_req),
        .ptr_i     (ptr_q),
        .winner_o  (win),
        .any_req_o (any_req)
    );

    // Constant-index selection keeps the mux free of out-of-range index widths.
    always_comb begin
        cur_dat = '0;
        win_dat = '0;
        cur_oh  = '0;
        win_oh  = '0;
        cur_req = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SEL_W'(i) == cur_q) begin
                cur_dat   = bus.src_data[i*DATA_W +: DATA_W];
                cur_oh[i] = 1'b1;
                cur_req   = bus.src_req[i];
            end
            if (SEL_W'(i) == win) begin
                win_dat   = bus.src_data[i*DATA_W +: DATA_W];
                win_oh[i] = 1'b1;
            end
        end
    end

`ifdef BUS_MUX_OVERRIDE_EN
    assign keep = (state_q == GRANT) && !ovr_q && cur_req && (hold_q < HOLD_LAST);
`else
    assign keep = (state_q == GRANT) && cur_req && (hold_q < HOLD_LAST);
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        hold_d  = '0;
        bus_d   = '0;
        valid_d = 1'b0;
        grant_d = '0;
        code_d  = '0;
`ifdef BUS_MUX_OVERRIDE_EN
        ovr_d   = 1'b0;
        if (bus.ovr_req) begin
            state_d = GRANT;
            ovr_d   = 1'b1;
            bus_d   = bus.ovr_data;
            valid_d = 1'b1;
            code_d  = OVR_CODE;
        end else
`endif
        if (keep) begin
            hold_d  = hold_q + HOLD_W'(1);
            bus_d   = cur_dat;
            valid_d = 1'b1;
            grant_d = cur_oh;
            code_d  = cur_q;
        end else if (any_req) begin
            // Hand-over happens in the same edge, so the bus never idles between grants.
            state_d = GRANT;
            cur_d   = win;
            ptr_d   = (win == SEL_W'(NUM_SRC - 1)) ? '0 : win + SEL_W'(1);
            bus_d   = win_dat;
            valid_d = 1'b1;
            grant_d = win_oh;
            code_d  = win;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cur_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            bus_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            code_q  <= '0;
`ifdef BUS_MUX_OVERRIDE_EN
            ovr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            bus_q   <= bus_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            code_q  <= code_d;
`ifdef BUS_MUX_OVERRIDE_EN
            ovr_q   <= ovr_d;
`endif
        end
    end

    assign bus.bus_out    = bus_q;
    assign bus.bus_valid  = valid_q;
    assign bus.grant      = grant_q;
    assign bus.grant_code = code_q;

endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Parametrised, registered successor to the datapath bus multiplexer.
- NUM_SRC sources of DATA_W bits each request the bus. A round-robin arbiter with a bounded hold time grants one source at a time.
- The granted source's data is driven onto a registered bus output, together with a valid flag and the grant as one-hot and encoded.
- Sits between register file / special registers / memory data register and all bus consumers.

Parameters:
- DATA_W, 32, width of each source and of the bus.
- NUM_SRC, 24, number of requesting sources (2..64; need not be a power of two).
- MAX_HOLD, 4, maximum consecutive cycles one grant is held (>=1).
- SEL_W (localparam), $clog2(NUM_SRC+1), width of the encoded grant. The extra code is reserved for the override.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset; asynchronous, active-low.
- src_data  in  NUM_SRC*DATA_W  flattened source data; source i occupies bits [i*DATA_W +: DATA_W].
- src_req  in  NUM_SRC  per-source bus request, level-sensitive.
- bus_out  out  DATA_W  registered bus value.
- bus_valid  out  1  bus_out holds granted data this cycle.
- grant  out  NUM_SRC  registered one-hot grant; all zero when idle or overridden.
- grant_code  out  SEL_W  registered encoded grant.
- ovr_req  in  1  override request (only with BUS_MUX_OVERRIDE_EN).
- ovr_data  in  DATA_W  override data (only with BUS_MUX_OVERRIDE_EN).

Behaviour:
- Reset (clear=0, async, any time including mid-grant):
  - bus_out=0, bus_valid=0, grant=0, grant_code=0.
  - state=IDLE, hold_cnt=0, ptr=0.
- Winner w (combinational): first i with src_req[i]=1, scanning ptr, ptr+1, ... NUM_SRC-1, 0, ... ptr-1.
- State machine: IDLE and GRANT. cur is the currently granted index. All updates occur at the rising edge.
  - keep = (state==GRANT) && src_req[cur] && (hold_cnt < MAX_HOLD-1).
  - If keep: cur unchanged, hold_cnt++, bus_out<=src_data[cur].
  - Else if |src_req: state=GRANT, cur=w, hold_cnt=0, ptr=(w+1) mod NUM_SRC, bus_out<=src_data[w]. There is no idle bubble between grants.
  - Else: state=IDLE, bus_out<=0, grant=0, grant_code=0, ptr unchanged.
- Outputs in GRANT: bus_valid=1, grant=onehot(cur), grant_code=cur.
- Latency: a request seen at edge t produces grant, bus_out and bus_valid after edge t, i.e. one cycle. bus_out carries the data sampled at that edge. In GRANT, bus_out re-samples the granted source every cycle.
- Hold expiry: when only cur is requesting, w wraps back to cur and cur is regranted with hold_cnt=0. When other sources are requesting, the next one after cur wins.
- Request drop: src_req[cur] falling re-arbitrates at the same edge.
- Index range: grant_code never exceeds NUM_SRC-1 in normal operation. ptr wraps from NUM_SRC-1 to 0.
- Timing: no combinational path from inputs to outputs.

Optional Feature:
- Macro: BUS_MUX_OVERRIDE_EN.
- With the macro:
  - ovr_req/ovr_data ports exist.
  - ovr_req=1 at an edge takes priority over everything: bus_out<=ovr_data, bus_valid=1, grant=0, grant_code=NUM_SRC, hold_cnt=0, state=GRANT with no source.
  - ptr is unchanged during override.
  - The first edge with ovr_req=0 arbitrates normally from ptr.
- Without the macro:
  - The ports are absent and grant_code never equals NUM_SRC.
  - SEL_W keeps the same value.

Decomposition:
- Package bus_mux_pkg holds:
  - the state enum (IDLE, GRANT);
  - a function computing SEL_W;
  - the reserved override code constant.
- One sub-module, rr_arbiter, is natural:
  - purely combinational;
  - inputs src_req and ptr; outputs winner index and any_req.
- The top level owns all registers, hold_cnt and the FSM.

Test Plan:
- Reset: drive clear=0 mid-grant with src_req=all ones. All outputs go to 0 immediately. After release, src_req[0]=1 gives grant=1 and grant_code=0 one edge later.
- Latency: NUM_SRC=24, src_req[5]=1, src_data[5]=32'hDEAD_BEEF. Expect bus_out=DEADBEEF, bus_valid=1, grant_code=5 after one edge. When src_data[5] changes, bus_out follows the next cycle.
- Round-robin/hold: src_req[2], src_req[7] and src_req[23] held high, MAX_HOLD=4. Expect grants 2,2,2,2,7,7,7,7,23,23,23,23,2… with no gaps.
- Wrap, single requester: only src_req[23] high for 10 cycles. Expect continuous grant_code=23, bus_valid=1, hold_cnt resetting every 4 cycles, ptr wrapping to 0.
- Early release: src_req[3] drops after 2 cycles while src_req[4]=1. Expect grant_code=4 at the next edge with bus_valid still 1. When all requests drop, expect bus_valid=0 and bus_out=0.
- Override (macro defined): ovr_req=1 and ovr_data=32'h1234 during a grant of 7, with src_req[9]=1. Expect grant_code=24, grant=0, bus_out=0x1234. Releasing ovr_req gives grant_code=9.
